// File: rtl/rom_stream_pkg.sv
// Shared definitions for the ROM stream loader.
// Holds the loader FSM state type, default widths and the beat-count helpers
// used by rom_stream_loader and word_serializer.
package rom_stream_pkg;

  localparam int unsigned DefAddrW    = 2;
  localparam int unsigned DefDataW    = 64;
  localparam int unsigned DefBeatW    = 16;
  localparam int unsigned DefNumWords = 3;

  localparam int unsigned BeatsPerWord = DefDataW / DefBeatW;
  localparam int unsigned BeatCntW     = (BeatsPerWord > 1) ? $clog2(BeatsPerWord) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StSend,
    StDone
  } state_e;

  // Counter width for a given beat count; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Splits one captured ROM word into BeatW-bit beats, least-significant beat first.
// Ports:
//   clk_i, rst_i  clock and synchronous active-high reset
//   load_i        capture data_i and restart the beat counter
//   advance_i     current beat consumed; shift to the next one
//   data_i        word to serialize
//   beat_o        current beat (low BeatW bits of the shift register)
//   last_beat_o   current beat is the final beat of the word
module word_serializer
  import rom_stream_pkg::*;
#(
  parameter int unsigned DataW = DefDataW,
  parameter int unsigned BeatW = DefBeatW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             advance_i,
  input  logic [DataW-1:0] data_i,
  output logic [BeatW-1:0] beat_o,
  output logic             last_beat_o
);

  localparam int unsigned Beats = DataW / BeatW;
  localparam int unsigned CntW  = cnt_width(Beats);
  localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

  logic [DataW-1:0] shreg_d, shreg_q;
  logic [CntW-1:0]  cnt_d, cnt_q;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shreg_d = data_i;
      cnt_d   = '0;
    end else if (advance_i) begin
      shreg_d = shreg_q >> BeatW;
      cnt_d   = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign beat_o      = shreg_q[BeatW-1:0];
  assign last_beat_o = (cnt_q == LastCnt);

endmodule

// File: rtl/rom_stream_loader.sv
// Reads ROM words 0..NUM_WORDS-1 on request and streams them out as beats.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start               run request, honoured only when idle
//   busy / done         run in progress / one-cycle completion pulse
//   rom_ad / rom_data   registered ROM address and its combinational data
//   out_valid/out_ready beat handshake
//   out_data            current beat, LSB beat of each word first
//   out_last            final beat of the final word
//   out_word            word index of the current beat
//   checksum            XOR of all accepted beats (only with
//                       ROM_STREAM_LOADER_CHECKSUM_EN defined)
module rom_stream_loader
  import rom_stream_pkg::*;
#(
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned BEAT_W    = DefBeatW,
  parameter int unsigned NUM_WORDS = DefNumWords
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_ad,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_last,
`ifdef ROM_STREAM_LOADER_CHECKSUM_EN
  output logic [BEAT_W-1:0] checksum,
`endif
  output logic [ADDR_W-1:0] out_word
);

  localparam logic [ADDR_W-1:0] LastWord = ADDR_W'(NUM_WORDS - 1);

  state_e            state_d, state_q;
  // Doubles as the word index: word n always lives at ROM address n.
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              ser_load, ser_advance;
  logic [BEAT_W-1:0] beat;
  logic              last_beat;

  word_serializer #(
    .DataW (DATA_W),
    .BeatW (BEAT_W)
  ) u_word_serializer (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_i      (ser_load),
    .advance_i   (ser_advance),
    .data_i      (rom_data),
    .beat_o      (beat),
    .last_beat_o (last_beat)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ser_load    = 1'b0;
    ser_advance = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        // rom_ad settled at the previous edge, so rom_data is valid now.
        ser_load = 1'b1;
        state_d  = StSend;
      end
      StSend: begin
        if (out_ready) begin
          ser_advance = 1'b1;
          if (last_beat) begin
            if (addr_q == LastWord) begin
              state_d = StDone;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = StFetch;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign rom_ad    = addr_q;
  assign out_valid = (state_q == StSend);
  assign out_data  = out_valid ? beat : '0;
  assign out_word  = out_valid ? addr_q : '0;
  assign out_last  = out_valid && last_beat && (addr_q == LastWord);

`ifdef ROM_STREAM_LOADER_CHECKSUM_EN
  logic [BEAT_W-1:0] checksum_d, checksum_q;

  always_comb begin
    checksum_d = checksum_q;
    if (state_q == StIdle && start) begin
      checksum_d = '0;
    end else if (ser_advance) begin
      checksum_d = checksum_q ^ beat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_rom_stream_loader.sv
module tb_rom_stream_loader;
  localparam int unsigned AW  = 2;
  localparam int unsigned DW  = 64;
  localparam int unsigned BW  = 16;
  localparam int unsigned NW  = 3;
  localparam int unsigned BPW = DW / BW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, out_ready;
  logic          busy, done, out_valid, out_last;
  logic [AW-1:0] rom_ad, out_word;
  logic [DW-1:0] rom_data;
  logic [BW-1:0] out_data;
`ifdef ROM_STREAM_LOADER_CHECKSUM_EN
  logic [BW-1:0] checksum;
  logic [31:0]   checksum2;
`endif

  logic          start2, out_ready2;
  logic          busy2, done2, out_valid2, out_last2;
  logic [AW-1:0] rom_ad2, out_word2;
  logic [DW-1:0] rom_data2;
  logic [31:0]   out_data2;

  function automatic logic [63:0] rom_word(input logic [1:0] a);
    case (a)
      2'd0:    return 64'h0001_0000_0000_0000;
      2'd1:    return 64'hfedc_ba98_7654_3210;
      2'd2:    return 64'h0123_4567_89ab_cdef;
      default: return 64'hdead_beef_cafe_f00d;
    endcase
  endfunction

  always_comb rom_data  = rom_word(rom_ad);
  always_comb rom_data2 = rom_word(rom_ad2);

  rom_stream_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rom_ad    (rom_ad),
    .rom_data  (rom_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
`ifdef ROM_STREAM_LOADER_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .out_word  (out_word)
  );

  rom_stream_loader #(
    .ADDR_W    (2),
    .DATA_W    (64),
    .BEAT_W    (32),
    .NUM_WORDS (1)
  ) dut2 (
    .clk       (clk),
    .rst       (rst),
    .start     (start2),
    .busy      (busy2),
    .done      (done2),
    .rom_ad    (rom_ad2),
    .rom_data  (rom_data2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .out_data  (out_data2),
    .out_last  (out_last2),
`ifdef ROM_STREAM_LOADER_CHECKSUM_EN
    .checksum  (checksum2),
`endif
    .out_word  (out_word2)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the expected beat sequence of a run, consumed one beat per handshake.
  typedef struct {
    logic [BW-1:0] data;
    logic [AW-1:0] word;
    logic          last;
    logic          endw;
  } beat_t;

  typedef struct {
    int            rel;
    logic [BW-1:0] data;
    logic [AW-1:0] ad;
    logic          last;
  } acc_t;

  beat_t         exp_q[$];
  bit            m_busy, m_done_now, mev, mon_en;
  int            m_gap;
  logic [BW-1:0] m_chk;
  beat_t         mh;
  acc_t          ma;
  acc_t          acc_log[$];
  int            done_log[$];
  int            cyc = 0;
  int            start_cyc = 0;
  logic [BW-1:0] exp_beats [12];

  function automatic void push_run();
    beat_t         e;
    logic [63:0]   w64;
    for (int w = 0; w < NW; w++) begin
      w64 = rom_word(AW'(w));
      for (int b = 0; b < BPW; b++) begin
        e.data = w64[b*BW +: BW];
        e.word = AW'(w);
        e.last = (w == NW - 1) && (b == BPW - 1);
        e.endw = (b == BPW - 1);
        exp_q.push_back(e);
      end
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      mev = m_busy && !m_done_now && (m_gap == 0);
      check("busy", busy, m_busy);
      check("done", done, m_done_now);
      check("out_valid", out_valid, mev);
      if (mev) begin
        if (exp_q.size() == 0) begin
          check("beat_queue_nonempty", exp_q.size(), 1);
        end else begin
          mh = exp_q[0];
          check("out_data", out_data, mh.data);
          check("out_word", out_word, mh.word);
          check("out_last", out_last, mh.last);
          check("rom_ad", rom_ad, mh.word);
        end
      end
`ifdef ROM_STREAM_LOADER_CHECKSUM_EN
      if (m_done_now) check("checksum_model", checksum, m_chk);
`endif
      if (!rst && out_valid && out_ready) begin
        ma.rel  = cyc - start_cyc;
        ma.data = out_data;
        ma.ad   = rom_ad;
        ma.last = out_last;
        acc_log.push_back(ma);
      end
      if (done) done_log.push_back(cyc - start_cyc);
      // Advance the model to what must hold after the coming edge.
      if (rst) begin
        m_busy = 0; m_done_now = 0; m_gap = 0; m_chk = '0;
        exp_q.delete();
      end else if (m_done_now) begin
        m_done_now = 0;
        m_busy     = 0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_gap = 1; m_chk = '0;
          exp_q.delete();
          push_run();
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (out_ready && exp_q.size() > 0) begin
        mh    = exp_q.pop_front();
        m_chk = m_chk ^ mh.data;
        if (mh.last) m_done_now = 1;
        else if (mh.endw) m_gap = 1;
      end
    end
  end

  function automatic int base_rel(input int i);
    return (i / 4) * 5 + (i % 4) + 2;
  endfunction

  initial begin
    exp_beats = '{16'h0000, 16'h0000, 16'h0000, 16'h0001,
                  16'h3210, 16'h7654, 16'hba98, 16'hfedc,
                  16'hcdef, 16'h89ab, 16'h4567, 16'h0123};
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    start2 = 1'b0; out_ready2 = 1'b1;
    mon_en = 1'b0; m_busy = 0; m_done_now = 0; m_gap = 0; m_chk = '0;
    repeat (3) @(posedge clk);
    #1 mon_en = 1'b1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_valid", out_valid, 0);
    check("reset_rom_ad", rom_ad, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_last", out_last, 0);
    check("reset_out_word", out_word, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic run, ready held high.
    acc_log.delete(); done_log.delete();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (c == 0) start_cyc = cyc;
      start = (c == 0);
    end
    check("t1_nbeats", acc_log.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < acc_log.size()) begin
        check("t1_data", acc_log[i].data, exp_beats[i]);
        check("t1_cycle", acc_log[i].rel, base_rel(i));
        check("t1_rom_ad", acc_log[i].ad, i / 4);
        check("t1_last", acc_log[i].last, (i == 11));
      end
    end
    check("t1_ndone", done_log.size(), 1);
    if (done_log.size() > 0) check("t1_done_cycle", done_log[0], 16);
`ifdef ROM_STREAM_LOADER_CHECKSUM_EN
    check("t1_checksum", checksum, 16'h0001);
`endif

    // Backpressure on beat 7654 for three cycles.
    acc_log.delete(); done_log.delete();
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      if (c == 0) start_cyc = cyc;
      start     = (c == 0);
      out_ready = !(c >= 8 && c <= 10);
    end
    out_ready = 1'b1;
    check("t2_nbeats", acc_log.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < acc_log.size()) begin
        check("t2_data", acc_log[i].data, exp_beats[i]);
        check("t2_cycle", acc_log[i].rel, base_rel(i) + ((i >= 5) ? 3 : 0));
      end
    end
    if (done_log.size() > 0) check("t2_done_cycle", done_log[0], 19);
    check("t2_ndone", done_log.size(), 1);

    // start held during a run is ignored; start right after done starts a second run.
    acc_log.delete(); done_log.delete();
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (c == 0) start_cyc = cyc;
      start = (c <= 15) || (c == 17);
    end
    start = 1'b0;
    check("t3_nbeats", acc_log.size(), 24);
    for (int i = 0; i < 24; i++)
      if (i < acc_log.size()) check("t3_data", acc_log[i].data, exp_beats[i % 12]);
    check("t3_ndone", done_log.size(), 2);
    if (done_log.size() == 2) begin
      check("t3_done0", done_log[0], 16);
      check("t3_done1", done_log[1], 33);
    end

    // Reset in the cycle ba98 is valid, then restart.
    acc_log.delete(); done_log.delete();
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (c == 0) start_cyc = cyc;
      start = (c == 0);
      rst   = (c == 9);
      if (c == 10) begin
        check("t4_busy_after_rst", busy, 0);
        check("t4_valid_after_rst", out_valid, 0);
        check("t4_rom_ad_after_rst", rom_ad, 0);
        check("t4_done_after_rst", done, 0);
      end
    end
    check("t4_nbeats", acc_log.size(), 6);
    check("t4_ndone", done_log.size(), 0);
    acc_log.delete(); done_log.delete();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (c == 0) start_cyc = cyc;
      start = (c == 0);
    end
    check("t4_restart_nbeats", acc_log.size(), 12);
    if (acc_log.size() > 0) begin
      check("t4_restart_first", acc_log[0].data, 16'h0000);
      check("t4_restart_first_cycle", acc_log[0].rel, 2);
    end
    if (done_log.size() > 0) check("t4_restart_done", done_log[0], 16);

    // One-word, 32-bit-beat instance.
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      start2 = (c == 0);
      case (c)
        1: begin
          check("n1_busy_fetch", busy2, 1);
          check("n1_valid_fetch", out_valid2, 0);
        end
        2: begin
          check("n1_valid0", out_valid2, 1);
          check("n1_data0", out_data2, 32'h0000_0000);
          check("n1_last0", out_last2, 0);
          check("n1_rom_ad", rom_ad2, 0);
        end
        3: begin
          check("n1_valid1", out_valid2, 1);
          check("n1_data1", out_data2, 32'h0001_0000);
          check("n1_last1", out_last2, 1);
        end
        4: begin
          check("n1_done", done2, 1);
          check("n1_valid_done", out_valid2, 0);
        end
        5: begin
          check("n1_idle_busy", busy2, 0);
          check("n1_idle_done", done2, 0);
        end
        default: ;
      endcase
    end

    // Random starts, backpressure and occasional reset, all checked by the model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      start     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 499) == 0);
    end
    rst = 1'b0; start = 1'b0; out_ready = 1'b1;
    repeat (30) @(posedge clk);

    // Random ready still yields the same checksum.
    acc_log.delete(); done_log.delete();
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (c == 0) start_cyc = cyc;
      start     = (c == 0);
      out_ready = ($urandom_range(0, 2) != 0);
    end
    out_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("t6_nbeats", acc_log.size(), 12);
    check("t6_ndone", done_log.size(), 1);
`ifdef ROM_STREAM_LOADER_CHECKSUM_EN
    check("t6_checksum", checksum, 16'h0001);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
